// File: rtl/hazard_ctrl.sv
// Hazard and control unit for a 5-stage (F, D, E, M, W) pipelined core.
// Produces the E-stage forwarding selects and the stall/flush controls
// for the stage registers. A small FSM tracks data-memory wait states
// and raises a sticky timeout flag. Two saturating counters record
// stall and flush events for performance debug.
//
// Handshake: the data memory signals completion with MemReadyM in the
// same cycle as the access. Every cycle with MemReqM=1 and MemReadyM=0
// is a wait cycle, and it freezes the whole pipeline combinationally.
module hazard_ctrl #(
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 255,
  parameter int TO_W    = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       RA1D,
  input  logic [3:0]       RA2D,
  input  logic [3:0]       RA1E,
  input  logic [3:0]       RA2E,
  input  logic [3:0]       WA3E,
  input  logic [3:0]       WA3M,
  input  logic [3:0]       WA3W,
  input  logic             RegWriteM,
  input  logic             RegWriteW,
  input  logic             MemtoRegE,
  input  logic             PCSrcD,
  input  logic             PCSrcE,
  input  logic             PCSrcM,
  input  logic             PCSrcW,
  input  logic             BranchTakenE,
  input  logic             MemReqM,
  input  logic             MemReadyM,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,
  output logic             StallF,
  output logic             StallD,
  output logic             StallE,
  output logic             StallM,
  output logic             FlushD,
  output logic             FlushE,
  output logic             FlushW,
  output logic             MemErr,
  output logic [CNT_W-1:0] StallCount,
  output logic [CNT_W-1:0] FlushCount,
  output logic             dbg_state
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } mem_state_t;

  localparam logic [TO_W-1:0]  TO_ONE    = TO_W'(1);
  localparam logic [TO_W-1:0]  TO_LIMIT  = TO_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  mem_state_t      state_q, state_d;
  logic [TO_W-1:0] wait_q, wait_d;
  logic            err_set;

  logic            ldstall;
  logic            pcpend;
  logic            memstall;

  // Register 15 is the PC and is never forwarded; M has priority over W.
  always_comb begin
    ForwardAE = 2'b00;
    ForwardBE = 2'b00;
    if (RegWriteM && (RA1E == WA3M) && (WA3M != 4'd15))
      ForwardAE = 2'b10;
    else if (RegWriteW && (RA1E == WA3W) && (WA3W != 4'd15))
      ForwardAE = 2'b01;
    if (RegWriteM && (RA2E == WA3M) && (WA3M != 4'd15))
      ForwardBE = 2'b10;
    else if (RegWriteW && (RA2E == WA3W) && (WA3W != 4'd15))
      ForwardBE = 2'b01;
  end

  assign ldstall  = MemtoRegE && ((RA1D == WA3E) || (RA2D == WA3E));
  assign pcpend   = PCSrcD || PCSrcE || PCSrcM;
  assign memstall = MemReqM && !MemReadyM;

  // Stall/flush controls: memory freeze dominates, and reset forces a bubble everywhere.
  always_comb begin
    StallF = ldstall || pcpend;
    StallD = ldstall;
    StallE = 1'b0;
    StallM = 1'b0;
    FlushD = pcpend || PCSrcW || BranchTakenE;
    FlushE = ldstall || BranchTakenE;
    FlushW = 1'b0;
    if (memstall) begin
      // Freeze F..M; W drains its instruction while a bubble follows it.
      StallF = 1'b1;
      StallD = 1'b1;
      StallE = 1'b1;
      StallM = 1'b1;
      FlushD = 1'b0;
      FlushE = 1'b0;
      FlushW = 1'b1;
    end
    if (!reset) begin
      StallF = 1'b0;
      StallD = 1'b0;
      StallE = 1'b0;
      StallM = 1'b0;
      FlushD = 1'b1;
      FlushE = 1'b1;
      FlushW = 1'b1;
    end
  end

  // Memory wait FSM next state; wait_d counts consecutive stalled cycles.
  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    case (state_q)
      S_IDLE: begin
        if (memstall) begin
          state_d = S_WAIT;
          wait_d  = TO_ONE;
        end
      end
      S_WAIT: begin
        if (!memstall) begin
          state_d = S_IDLE;
          wait_d  = '0;
        end else if (wait_q != '1) begin
          wait_d = wait_q + TO_ONE;
        end
      end
      default: begin
        state_d = S_IDLE;
        wait_d  = '0;
      end
    endcase
    err_set = memstall && (wait_d == TO_LIMIT);
  end

  // Memory wait FSM state, wait counter and sticky timeout flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      wait_q  <= '0;
      MemErr  <= 1'b0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      if (err_set)
        MemErr <= 1'b1;
    end
  end

  // Saturating performance counters for stall and flush events.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      StallCount <= '0;
      FlushCount <= '0;
    end else begin
      if (StallF && (StallCount != '1))
        StallCount <= StallCount + CNT_ONE;
      if ((FlushD || FlushE) && (FlushCount != '1))
        FlushCount <= FlushCount + CNT_ONE;
    end
  end

  assign dbg_state = state_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl. It uses small parameters so that the
// timeout and counter saturation are reached quickly:
// CNT_W=3, TIMEOUT=4.
module tb_hazard_ctrl;

  localparam int CNT_W   = 3;
  localparam int TIMEOUT = 4;
  localparam int TO_W    = 8;

  logic             clk;
  logic             reset;
  logic [3:0]       RA1D, RA2D, RA1E, RA2E, WA3E, WA3M, WA3W;
  logic             RegWriteM, RegWriteW, MemtoRegE;
  logic             PCSrcD, PCSrcE, PCSrcM, PCSrcW, BranchTakenE;
  logic             MemReqM, MemReadyM;
  logic [1:0]       ForwardAE, ForwardBE;
  logic             StallF, StallD, StallE, StallM;
  logic             FlushD, FlushE, FlushW;
  logic             MemErr;
  logic [CNT_W-1:0] StallCount, FlushCount;
  logic             dbg_state;

  int checks = 0;
  int errors = 0;

  hazard_ctrl #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT), .TO_W(TO_W)) dut (
    .clk(clk), .reset(reset),
    .RA1D(RA1D), .RA2D(RA2D), .RA1E(RA1E), .RA2E(RA2E),
    .WA3E(WA3E), .WA3M(WA3M), .WA3W(WA3W),
    .RegWriteM(RegWriteM), .RegWriteW(RegWriteW), .MemtoRegE(MemtoRegE),
    .PCSrcD(PCSrcD), .PCSrcE(PCSrcE), .PCSrcM(PCSrcM), .PCSrcW(PCSrcW),
    .BranchTakenE(BranchTakenE), .MemReqM(MemReqM), .MemReadyM(MemReadyM),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
    .FlushD(FlushD), .FlushE(FlushE), .FlushW(FlushW),
    .MemErr(MemErr), .StallCount(StallCount), .FlushCount(FlushCount),
    .dbg_state(dbg_state)
  );

  // Clock: 10 ns period, rising edges at 5, 15, 25, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Watchdog so the run always ends.
  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Stall vector {F,D,E,M} and flush vector {D,E,W}.
  task automatic chk_sf(input string tag, input logic [31:0] es, input logic [31:0] ef);
    chk({tag, "_stall"}, 32'({StallF, StallD, StallE, StallM}), es);
    chk({tag, "_flush"}, 32'({FlushD, FlushE, FlushW}), ef);
  endtask

  task automatic chk_cnt(input string tag, input logic [31:0] es, input logic [31:0] ef);
    chk({tag, "_scnt"}, 32'(StallCount), es);
    chk({tag, "_fcnt"}, 32'(FlushCount), ef);
  endtask

  task automatic idle();
    RA1D = 4'd0; RA2D = 4'd0; RA1E = 4'd0; RA2E = 4'd0;
    WA3E = 4'd0; WA3M = 4'd0; WA3W = 4'd0;
    RegWriteM = 1'b0; RegWriteW = 1'b0; MemtoRegE = 1'b0;
    PCSrcD = 1'b0; PCSrcE = 1'b0; PCSrcM = 1'b0; PCSrcW = 1'b0;
    BranchTakenE = 1'b0; MemReqM = 1'b0; MemReadyM = 1'b0;
  endtask

  initial begin
    // ---- reset state ----
    reset = 1'b0;
    idle();
    RegWriteM = 1'b1; WA3M = 4'd3; RA1E = 4'd3;
    #1;
    chk_sf("rst", 'b0000, 'b111);
    chk("rst_err", 32'(MemErr), 0);
    chk_cnt("rst", 0, 0);
    chk("rst_state", 32'(dbg_state), 0);
    chk("rst_fwd_comb", 32'(ForwardAE), 2);
    @(negedge clk);
    #2;
    reset = 1'b1;
    idle();
    @(negedge clk);
    #1;
    chk_sf("post_rst", 'b0000, 'b000);
    chk_cnt("post_rst", 0, 0);
    chk("post_rst_state", 32'(dbg_state), 0);

    // ---- forwarding ----
    RegWriteM = 1'b1; WA3M = 4'd3; RA1E = 4'd3; RA2E = 4'd3;
    #1;
    chk("fwd_m_a", 32'(ForwardAE), 2);
    chk("fwd_m_b", 32'(ForwardBE), 2);
    RegWriteW = 1'b1; WA3W = 4'd3;
    #1;
    chk("fwd_mw_prio", 32'(ForwardAE), 2);
    WA3M = 4'd4;
    #1;
    chk("fwd_w_a", 32'(ForwardAE), 1);
    RA2E = 4'd4;
    #1;
    chk("fwd_m_b2", 32'(ForwardBE), 2);
    WA3M = 4'd15; WA3W = 4'd15; RA1E = 4'd15; RA2E = 4'd15;
    #1;
    chk("fwd_r15_a", 32'(ForwardAE), 0);
    chk("fwd_r15_b", 32'(ForwardBE), 0);
    WA3M = 4'd3; WA3W = 4'd3; RA1E = 4'd3; RA2E = 4'd3;
    RegWriteM = 1'b0; RegWriteW = 1'b0;
    #1;
    chk("fwd_nowr_a", 32'(ForwardAE), 0);
    idle();

    // ---- load-use stall, counted over one edge ----
    @(negedge clk);
    MemtoRegE = 1'b1; WA3E = 4'd5; RA2D = 4'd5;
    #1;
    chk_sf("ldu_ra2", 'b1100, 'b010);
    @(posedge clk);
    #1;
    chk_cnt("ldu_edge", 1, 1);
    idle();
    @(negedge clk);
    MemtoRegE = 1'b1; WA3E = 4'd5; RA1D = 4'd5;
    #1;
    chk_sf("ldu_ra1", 'b1100, 'b010);
    MemtoRegE = 1'b0;
    #1;
    chk_sf("ldu_noload", 'b0000, 'b000);
    idle();

    // ---- branch and PC-write flushes ----
    @(negedge clk);
    BranchTakenE = 1'b1;
    #1;
    chk_sf("br", 'b0000, 'b110);
    @(posedge clk);
    #1;
    chk_cnt("br_edge", 1, 2);
    idle();
    @(negedge clk);
    PCSrcM = 1'b1;
    #1;
    chk_sf("pcm", 'b1000, 'b100);
    PCSrcM = 1'b0; PCSrcD = 1'b1;
    #1;
    chk_sf("pcd", 'b1000, 'b100);
    PCSrcD = 1'b0; PCSrcW = 1'b1;
    #1;
    chk_sf("pcw", 'b0000, 'b100);
    idle();
    MemtoRegE = 1'b1; WA3E = 4'd5; RA2D = 4'd5; BranchTakenE = 1'b1;
    #1;
    chk_sf("ldu_br", 'b1100, 'b110);
    idle();

    // ---- memory stall combinational cases ----
    @(negedge clk);
    MemReqM = 1'b1; MemReadyM = 1'b0; BranchTakenE = 1'b1;
    #1;
    chk_sf("mem_br", 'b1111, 'b001);
    MemReadyM = 1'b1; BranchTakenE = 1'b0;
    #1;
    chk_sf("mem_ready", 'b0000, 'b000);
    idle();

    // ---- memory wait, 3 stalled cycles ----
    @(negedge clk);
    MemReqM = 1'b1; MemReadyM = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      #1;
      chk_sf("mw_stall", 'b1111, 'b001);
      @(posedge clk);
      #1;
      chk("mw_state", 32'(dbg_state), 1);
      @(negedge clk);
    end
    MemReadyM = 1'b1;
    #1;
    chk_sf("mw_done", 'b0000, 'b000);
    @(posedge clk);
    #1;
    chk("mw_idle", 32'(dbg_state), 0);
    chk("mw_err", 32'(MemErr), 0);
    chk_cnt("mw_cnt", 4, 2);
    idle();

    // ---- timeout: 6 stalled cycles with TIMEOUT=4 ----
    @(negedge clk);
    MemReqM = 1'b1; MemReadyM = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      @(posedge clk);
      #1;
      chk("to_err", 32'(MemErr), (k >= TIMEOUT) ? 1 : 0);
      chk("to_state", 32'(dbg_state), 1);
    end
    @(negedge clk);
    MemReadyM = 1'b1;
    @(posedge clk);
    #1;
    chk("to_idle", 32'(dbg_state), 0);
    chk("to_err_sticky", 32'(MemErr), 1);
    chk_cnt("to_cnt_sat", 7, 2);
    idle();
    @(posedge clk);
    #1;
    chk("to_err_hold", 32'(MemErr), 1);

    // ---- reset asserted mid-wait ----
    @(negedge clk);
    MemReqM = 1'b1; MemReadyM = 1'b0;
    @(posedge clk);
    #1;
    chk("rw_state", 32'(dbg_state), 1);
    #2;
    reset = 1'b0;
    #1;
    chk("rw_err", 32'(MemErr), 0);
    chk_cnt("rw", 0, 0);
    chk_sf("rw_forced", 'b0000, 'b111);
    chk("rw_state_rst", 32'(dbg_state), 0);
    idle();
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("rw_rel_state", 32'(dbg_state), 0);
    chk_sf("rw_rel", 'b0000, 'b000);
    chk_cnt("rw_rel", 0, 0);

    // ---- counter saturation, StallF and FlushD held 10 cycles ----
    @(negedge clk);
    PCSrcD = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk);
      #1;
      chk_cnt("sat", (k > 7) ? 7 : k, (k > 7) ? 7 : k);
    end
    idle();
    @(posedge clk);
    #1;
    chk_cnt("sat_hold", 7, 7);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline hazard and control unit for the 5-stage pipelined core (F, D, E, M, W).
- Consumes the control bits the stage registers carry forward (PCSrc*, RegWrite*, MemtoReg*) and register indices.
- Drives the stall and flush inputs back into the stage registers, and the E-stage forwarding selects.
- Sequential content:
  - a data-memory wait FSM with a timeout error flag;
  - saturating stall and flush event counters for performance debug.

Parameters:
CNT_W, 16, width of the StallCount and FlushCount counters
TIMEOUT, 255, number of consecutive memory-wait cycles at which MemErr sets (1..2^TO_W-1)
TO_W, 8, width of the wait-cycle counter

Ports:
clk  in  1  rising-edge clock
reset  in  1  asynchronous, active-low reset
RA1D, RA2D  in  4  source registers of the instruction in D
RA1E, RA2E  in  4  source registers of the instruction in E
WA3E, WA3M, WA3W  in  4  destination registers in E, M and W
RegWriteM, RegWriteW  in  1  register write enables in M and W
MemtoRegE  in  1  the instruction in E is a load
PCSrcD, PCSrcE, PCSrcM, PCSrcW  in  1  the instruction in that stage writes the PC
BranchTakenE  in  1  branch resolved taken in E
MemReqM  in  1  the instruction in M accesses data memory
MemReadyM  in  1  data memory completes the access this cycle
ForwardAE, ForwardBE  out  2  operand select: 00 register file, 01 ResultW, 10 ALUResultM
StallF, StallD, StallE, StallM  out  1  hold the corresponding stage register
FlushD, FlushE, FlushW  out  1  clear the corresponding stage register to a bubble
MemErr  out  1  sticky memory-timeout flag
StallCount, FlushCount  out  CNT_W  saturating event counters

Behaviour:
- Reset, asynchronous, while reset=0:
  - FSM goes to IDLE; wait counter = 0.
  - MemErr = 0; StallCount = 0; FlushCount = 0.
  - Flush outputs are forced: FlushD = FlushE = FlushW = 1.
  - Stall outputs are forced: StallF = StallD = StallE = StallM = 0.
  - ForwardAE and ForwardBE stay combinational.
- Forwarding, combinational, zero latency (ForwardBE is identical in form, using RA2E):
  - ForwardAE = 10 if RegWriteM and RA1E == WA3M and WA3M != 15.
  - Otherwise ForwardAE = 01 if RegWriteW and RA1E == WA3W and WA3W != 15.
  - Otherwise ForwardAE = 00. M has priority over W.
- Load-use stall: ldstall = MemtoRegE and (RA1D == WA3E or RA2D == WA3E).
- PC-write pending: pcpend = PCSrcD or PCSrcE or PCSrcM.
- Memory stall: memstall = MemReqM and not MemReadyM. It is combinational, so it stalls in the same cycle.
- When memstall = 0, outputs follow the normal equations:
  - StallF = ldstall or pcpend; StallD = ldstall.
  - StallE = StallM = 0.
  - FlushD = pcpend or PCSrcW or BranchTakenE.
  - FlushE = ldstall or BranchTakenE.
  - FlushW = 0.
- When memstall = 1, it dominates all other terms:
  - StallF = StallD = StallE = StallM = 1.
  - FlushD = FlushE = 0.
  - FlushW = 1, so a bubble enters W; the instruction currently in W still completes.
- Memory FSM, states IDLE and WAIT:
  - IDLE -> WAIT when memstall; wait counter := 1.
  - WAIT with MemReadyM = 1 or MemReqM = 0 -> IDLE; counter := 0.
  - WAIT otherwise: stay; the counter increments and saturates at 2^TO_W - 1.
  - MemErr sets on the clock edge at which the counter would reach TIMEOUT, i.e. after TIMEOUT consecutive stalled cycles. It stays set until reset. The pipeline remains stalled; there is no abort.
- Counters, registered, one-cycle latency:
  - StallCount += 1 on each edge where StallF = 1.
  - FlushCount += 1 on each edge where (FlushD or FlushE) = 1.
  - Both saturate at all-ones and never wrap.
  - Cycles with reset asserted do not count.
- Reset asserted mid-wait: the FSM returns to IDLE immediately and MemErr clears. After release, the FSM re-enters WAIT only if memstall is still high.
- Simultaneous events:
  - ldstall and BranchTakenE together: StallF = StallD = 1, FlushE = 1, FlushD = 1. The branch squash wins for D.
  - memstall together with BranchTakenE: the branch is deferred by the freeze, because E holds.

Test Plan:
- Forward select and priority:
  - RegWriteM = 1, WA3M = 3, RA1E = 3 -> ForwardAE = 10.
  - Additionally RegWriteW = 1, WA3W = 3 -> still 10.
  - WA3M = 4 -> ForwardAE = 01.
  - WA3M = WA3W = 15 -> ForwardAE = 00.
- Load-use stall:
  - MemtoRegE = 1, WA3E = 5, RA2D = 5 -> StallF = StallD = FlushE = 1, FlushD = 0.
  - StallCount goes from 0 to 1 after one edge.
- Branch and PC-write flush:
  - BranchTakenE = 1 -> FlushD = FlushE = 1.
  - PCSrcM = 1 alone -> StallF = FlushD = 1, FlushE = 0.
  - PCSrcW = 1 alone -> FlushD = 1, StallF = 0.
- Memory wait:
  - MemReqM = 1, MemReadyM = 0 for 3 cycles, then 1 -> all Stall* = 1 and FlushW = 1 for exactly 3 cycles, FSM back in IDLE, MemErr = 0.
  - With TIMEOUT = 4: hold not-ready for 6 cycles -> MemErr = 1 after the 4th stalled edge and stays 1 after ready.
- Reset mid-wait:
  - Drop reset during WAIT with MemErr = 1 -> immediately MemErr = 0, counters = 0, Flush* = 1, Stall* = 0.
  - Release with MemReqM = 0 -> FSM in IDLE.
- Counter saturation:
  - CNT_W = 3, hold StallF high for 10 cycles -> StallCount stops at 7.
